// File: rtl/camera_pkg.sv
// Shared types and constants for the camera capture front end.
package camera_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        VBLANK,
        START,
        ACTIVE
    } capture_state_t;

    // Counts presented on every cycle that carries neither a pixel nor the frame start
    localparam logic [9:0] IDLE_X = 10'h3FF;
    localparam logic [8:0] IDLE_Y = 9'h1FF;

    localparam logic [9:0] DEFAULT_FRAME_WIDTH  = 10'd320;
    localparam logic [8:0] DEFAULT_FRAME_HEIGHT = 9'd240;

endpackage

// File: rtl/camera_capture_if.sv
// Camera byte bus in, per-pixel stream out. master = capture block, slave = camera/consumer side.
interface camera_capture_if;

    logic [7:0]  camera_data;
    logic        camera_href;
    logic        camera_vsync;
    logic [9:0]  frame_x_count;
    logic [8:0]  frame_y_count;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        frame_done;
    logic        frame_error;

    modport master (
        input  camera_data, camera_href, camera_vsync,
        output frame_x_count, frame_y_count, pixel_data, pixel_valid, frame_done, frame_error
    );

    modport slave (
        output camera_data, camera_href, camera_vsync,
        input  frame_x_count, frame_y_count, pixel_data, pixel_valid, frame_done, frame_error
    );

endinterface

// File: rtl/camera_capture_byte_pair_assembler.sv
// Pairs consecutive camera bytes into one RGB565 pixel; phase restarts whenever clear_i is high.
module camera_capture_byte_pair_assembler
    import camera_pkg::*;
#(
    parameter logic HIGH_BYTE_FIRST = 1'b1
) (
    input  logic       pixel_clock_in,
    input  logic       reset_n_in,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic [7:0] byte_i,
    output logic       phase_o,
    output logic       complete_o,
    output rgb565_t    pixel_o
);

    logic       phase_q;
    logic [7:0] first_q;

    always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            phase_q <= 1'b0;
            first_q <= 8'h00;
        end else if (clear_i) begin
            phase_q <= 1'b0;
        end else if (enable_i) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
                first_q <= byte_i;
            end
        end
    end

    always_comb begin
        phase_o    = phase_q;
        complete_o = enable_i & phase_q;
        pixel_o    = HIGH_BYTE_FIRST ? rgb565_t'({first_q, byte_i})
                                     : rgb565_t'({byte_i, first_q});
    end

endmodule

// File: rtl/camera_capture.sv
// Camera byte-stream capture: vsync/href framing to a per-pixel RGB565 stream with a
// one-cycle frame-start marker, end-of-frame pulse and malformed-frame flag.
module camera_capture
    import camera_pkg::*;
#(
    parameter logic [9:0] FRAME_WIDTH     = DEFAULT_FRAME_WIDTH,
    parameter logic [8:0] FRAME_HEIGHT    = DEFAULT_FRAME_HEIGHT,
    parameter logic       HIGH_BYTE_FIRST = 1'b1
) (
    input logic              pixel_clock_in,
    input logic              reset_n_in,
    camera_capture_if.master bus
);

    logic [7:0]     data_q;
    logic           href_q, vsync_q, href_prev_q, vsync_prev_q;
    capture_state_t state_q, state_d;
    logic [9:0]     x_cnt_q, x_cnt_d;
    logic [8:0]     line_cnt_q, line_cnt_d;
    logic           line_has_pix_q, line_has_pix_d;
    logic           err_q, err_d;

    logic           vsync_rise, vsync_fall, href_fall;
    logic           asm_en, pair_done, phase, in_window, capture, end_frame;
    rgb565_t        pixel;

    logic [9:0]     frame_x_q;
    logic [8:0]     frame_y_q;
    logic [15:0]    pixel_data_q;
    logic           pixel_valid_q, frame_done_q, frame_error_q;

    always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            data_q       <= 8'h00;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            href_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            data_q       <= bus.camera_data;
            href_q       <= bus.camera_href;
            vsync_q      <= bus.camera_vsync;
            href_prev_q  <= href_q;
            vsync_prev_q <= vsync_q;
        end
    end

    assign vsync_rise = vsync_q & ~vsync_prev_q;
    assign vsync_fall = ~vsync_q & vsync_prev_q;
    assign href_fall  = ~href_q & href_prev_q;
    assign asm_en     = (state_q == ACTIVE) & href_q;
    assign in_window  = (x_cnt_q < FRAME_WIDTH) && (line_cnt_q < FRAME_HEIGHT);
    // A pair completing in the same cycle vsync rises belongs to an aborted line
    assign capture    = pair_done & in_window & ~vsync_rise;
    assign end_frame  = (state_q == ACTIVE) & vsync_rise;

    camera_capture_byte_pair_assembler #(
        .HIGH_BYTE_FIRST(HIGH_BYTE_FIRST)
    ) u_byte_pair_assembler (
        .pixel_clock_in(pixel_clock_in),
        .reset_n_in    (reset_n_in),
        .enable_i      (asm_en),
        .clear_i       (~asm_en),
        .byte_i        (data_q),
        .phase_o       (phase),
        .complete_o    (pair_done),
        .pixel_o       (pixel)
    );

    always_comb begin
        state_d        = state_q;
        x_cnt_d        = x_cnt_q;
        line_cnt_d     = line_cnt_q;
        line_has_pix_d = line_has_pix_q;
        err_d          = err_q;
        unique case (state_q)
            SYNC_WAIT: if (vsync_q) state_d = VBLANK;
            VBLANK:    if (vsync_fall) state_d = START;
            START: begin
                x_cnt_d        = 10'd0;
                line_cnt_d     = 9'd0;
                line_has_pix_d = 1'b0;
                err_d          = 1'b0;
                state_d        = ACTIVE;
            end
            ACTIVE: begin
                if (capture) begin
                    x_cnt_d        = x_cnt_q + 10'd1;
                    line_has_pix_d = 1'b1;
                end
                if (pair_done && !in_window) err_d = 1'b1;
                if (href_fall) begin
                    x_cnt_d        = 10'd0;
                    line_has_pix_d = 1'b0;
                    if (line_has_pix_q && (line_cnt_q < FRAME_HEIGHT)) begin
                        line_cnt_d = line_cnt_q + 9'd1;
                    end
                    if (phase) err_d = 1'b1;
                end
                if (vsync_rise) begin
                    state_d = VBLANK;
                    if (href_q) begin
                        x_cnt_d        = 10'd0;
                        line_has_pix_d = 1'b0;
                        err_d          = 1'b1;
                    end
                    if (line_cnt_d != FRAME_HEIGHT) err_d = 1'b1;
                end
            end
            default: state_d = SYNC_WAIT;
        endcase
    end

    always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q        <= SYNC_WAIT;
            x_cnt_q        <= 10'd0;
            line_cnt_q     <= 9'd0;
            line_has_pix_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_cnt_q        <= x_cnt_d;
            line_cnt_q     <= line_cnt_d;
            line_has_pix_q <= line_has_pix_d;
            err_q          <= err_d;
        end
    end

    always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            frame_x_q     <= IDLE_X;
            frame_y_q     <= IDLE_Y;
            pixel_data_q  <= 16'h0000;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            frame_done_q <= end_frame;
            if (end_frame) frame_error_q <= err_d;
            if (capture) begin
                pixel_valid_q <= 1'b1;
                pixel_data_q  <= pixel;
                frame_x_q     <= x_cnt_q;
                frame_y_q     <= line_cnt_q;
            end else if (state_q == START) begin
                pixel_valid_q <= 1'b0;
                frame_x_q     <= 10'd0;
                frame_y_q     <= 9'd0;
            end else begin
                pixel_valid_q <= 1'b0;
                frame_x_q     <= IDLE_X;
                frame_y_q     <= IDLE_Y;
            end
        end
    end

    assign bus.frame_x_count = frame_x_q;
    assign bus.frame_y_count = frame_y_q;
    assign bus.pixel_data    = pixel_data_q;
    assign bus.pixel_valid   = pixel_valid_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.frame_error   = frame_error_q;

endmodule
